// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding selects, load/branch/MDU stall detection,
// branch/jump flush control, multi-cycle MDU occupancy tracking and a saturating stall counter.
module hazard_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic              uses_rs_d,
    input  logic              uses_rt_d,
    input  logic              branch_d,
    input  logic              taken_d,
    input  logic              jump_d,
    input  logic              mdu_start_d,
    input  logic              mdu_read_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_e,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              mem2reg_e,
    input  logic              mem2reg_m,
    input  logic              stat_clr,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        fwd_a_d,
    output logic [1:0]        fwd_b_d,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned CNT_BITS = $clog2(MDU_LAT + 1);

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_M    = 2'd1;
    localparam logic [1:0] FWD_W    = 2'd2;

    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_nxt;
    logic [CNT_W-1:0]    stall_cycles_nxt;

    logic wr_e_ok, wr_m_ok, wr_w_ok;
    logic e_hits_rs_d, e_hits_rt_d, m_hits_rs_d, m_hits_rt_d;
    logic lw_stall, br_stall, mdu_stall, stall;

    // A producer can only match when it writes a nonzero destination.
    always_comb begin
        wr_e_ok = reg_write_e && (rd_e != '0);
        wr_m_ok = reg_write_m && (rd_m != '0);
        wr_w_ok = reg_write_w && (rd_w != '0);
    end

    // Forwarding selects; the D path cannot take a load result still in M.
    always_comb begin
        fwd_a_e = FWD_NONE;
        fwd_b_e = FWD_NONE;
        fwd_a_d = FWD_NONE;
        fwd_b_d = FWD_NONE;

        if (wr_m_ok && (rs_e == rd_m))      fwd_a_e = FWD_M;
        else if (wr_w_ok && (rs_e == rd_w)) fwd_a_e = FWD_W;

        if (wr_m_ok && (rt_e == rd_m))      fwd_b_e = FWD_M;
        else if (wr_w_ok && (rt_e == rd_w)) fwd_b_e = FWD_W;

        if (wr_m_ok && !mem2reg_m && (rs_d == rd_m)) fwd_a_d = FWD_M;
        else if (wr_w_ok && (rs_d == rd_w))          fwd_a_d = FWD_W;

        if (wr_m_ok && !mem2reg_m && (rt_d == rd_m)) fwd_b_d = FWD_M;
        else if (wr_w_ok && (rt_d == rd_w))          fwd_b_d = FWD_W;
    end

    // Stall detection against the sources the D instruction really reads.
    always_comb begin
        e_hits_rs_d = wr_e_ok && uses_rs_d && (rd_e == rs_d);
        e_hits_rt_d = wr_e_ok && uses_rt_d && (rd_e == rt_d);
        m_hits_rs_d = wr_m_ok && uses_rs_d && (rd_m == rs_d);
        m_hits_rt_d = wr_m_ok && uses_rt_d && (rd_m == rt_d);

        lw_stall  = mem2reg_e && (e_hits_rs_d || e_hits_rt_d);
        br_stall  = branch_d && ((e_hits_rs_d || e_hits_rt_d) ||
                                 (mem2reg_m && (m_hits_rs_d || m_hits_rt_d)));
        mdu_stall = (mdu_start_d || mdu_read_d) && mdu_busy;
        stall     = lw_stall || br_stall || mdu_stall;

        stall_f = stall;
        stall_d = stall;
        flush_e = stall;
        flush_d = (taken_d || jump_d) && !stall;
    end

    // Busy is taken from the registered count only, keeping stall out of its fan-in.
    always_comb begin
        mdu_busy = (cnt != '0);
    end

    // Occupancy countdown; a start is only accepted when nothing stalls it.
    always_comb begin
        cnt_nxt = cnt;
        if (mdu_start_d && !stall) begin
            cnt_nxt = CNT_BITS'(MDU_LAT);
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_BITS'(1);
        end
    end

    // Clear wins over counting; counting stops at all-ones.
    always_comb begin
        stall_cycles_nxt = stall_cycles;
        if (stat_clr) begin
            stall_cycles_nxt = '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles_nxt = stall_cycles + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            cnt          <= cnt_nxt;
            stall_cycles <= stall_cycles_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations queued when a step is driven,
// popped and compared against the DUT just before the next rising edge.
`timescale 1ns/100ps
module tb_hazard_ctrl;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned MDU_LAT = 4;
    localparam int unsigned CNT_W   = 4;

    logic clk = 1'b0;
    logic rst;
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, rd_e, rd_m, rd_w;
    logic uses_rs_d, uses_rt_d, branch_d, taken_d, jump_d, mdu_start_d, mdu_read_d;
    logic reg_write_e, reg_write_m, reg_write_w, mem2reg_e, mem2reg_m, stat_clr;
    logic stall_f, stall_d, flush_d, flush_e, mdu_busy;
    logic [1:0] fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
    logic [CNT_W-1:0] stall_cycles;

    hazard_ctrl #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
        .branch_d(branch_d), .taken_d(taken_d), .jump_d(jump_d),
        .mdu_start_d(mdu_start_d), .mdu_read_d(mdu_read_d),
        .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem2reg_e(mem2reg_e), .mem2reg_m(mem2reg_m), .stat_clr(stat_clr),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   sc_exp      = 0;
    bit   exp_stall   = 1'b0;

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            0: return 32'(stall_f);
            1: return 32'(stall_d);
            2: return 32'(flush_e);
            3: return 32'(flush_d);
            4: return 32'(fwd_a_e);
            5: return 32'(fwd_b_e);
            6: return 32'(fwd_a_d);
            7: return 32'(fwd_b_d);
            8: return 32'(mdu_busy);
            default: return 32'(stall_cycles);
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sig = sig; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic exp_ctrl(input string tag, input bit st, input bit fd);
        exp_stall = st;
        push({tag, ".stall_f"}, 0, 32'(st));
        push({tag, ".stall_d"}, 1, 32'(st));
        push({tag, ".flush_e"}, 2, 32'(st));
        push({tag, ".flush_d"}, 3, 32'(fd));
        push({tag, ".stall_cycles"}, 9, 32'(sc_exp));
    endtask

    task automatic exp_fwd(input string tag, input int ae, input int be, input int ad, input int bd);
        push({tag, ".fwd_a_e"}, 4, 32'(ae));
        push({tag, ".fwd_b_e"}, 5, 32'(be));
        push({tag, ".fwd_a_d"}, 6, 32'(ad));
        push({tag, ".fwd_b_d"}, 7, 32'(bd));
    endtask

    task automatic exp_busy(input string tag, input bit b);
        push({tag, ".mdu_busy"}, 8, 32'(b));
    endtask

    task automatic check_all();
        exp_t e;
        logic [31:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = observe(e.sig);
            vectors++;
            assert (o === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    // Sample just before the edge, then advance the reference stall counter.
    task automatic finish_cycle();
        #7;
        check_all();
        @(posedge clk);
        if (rst || stat_clr) sc_exp = 0;
        else if (exp_stall && sc_exp != 15) sc_exp = sc_exp + 1;
        #1;
    endtask

    task automatic idle();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        uses_rs_d = 0; uses_rt_d = 0; branch_d = 0; taken_d = 0; jump_d = 0;
        mdu_start_d = 0; mdu_read_d = 0; reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
        mem2reg_e = 0; mem2reg_m = 0; stat_clr = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        mdu_read_d = 1;
        #3;
        exp_ctrl("reset", 0, 0);
        exp_fwd("reset", 0, 0, 0, 0);
        exp_busy("reset", 0);
        check_all();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // load-use with a jump in D: stalled, so no flush
        idle();
        rd_e = 5; mem2reg_e = 1; reg_write_e = 1; rs_d = 5; uses_rs_d = 1; jump_d = 1;
        exp_ctrl("lw_use", 1, 0);
        finish_cycle();

        idle();
        rd_m = 5; mem2reg_m = 1; reg_write_m = 1; rs_d = 5; uses_rs_d = 1; jump_d = 1;
        exp_ctrl("lw_in_m", 0, 1);
        exp_fwd("lw_in_m", 0, 0, 0, 0);
        finish_cycle();

        idle();
        rd_e = 5; mem2reg_e = 1; reg_write_e = 1; rs_d = 5; uses_rs_d = 0; rt_d = 6; uses_rt_d = 1;
        exp_ctrl("lw_unused_rs", 0, 0);
        finish_cycle();

        rt_d = 5;
        exp_ctrl("lw_rt", 1, 0);
        finish_cycle();

        idle();
        mem2reg_e = 1; reg_write_e = 1; uses_rs_d = 1;
        exp_ctrl("lw_r0", 0, 0);
        finish_cycle();

        // forwarding priority and zero register
        idle();
        rd_m = 7; rd_w = 7; reg_write_m = 1; reg_write_w = 1; rs_e = 7;
        exp_fwd("fwd_mw", 1, 0, 0, 0);
        exp_ctrl("fwd_mw", 0, 0);
        finish_cycle();

        reg_write_m = 0;
        exp_fwd("fwd_w_only", 2, 0, 0, 0);
        finish_cycle();

        reg_write_m = 1; rd_m = 0; rd_w = 0;
        exp_fwd("fwd_r0", 0, 0, 0, 0);
        finish_cycle();

        idle();
        rd_m = 7; rd_w = 9; reg_write_m = 1; reg_write_w = 1;
        rs_e = 7; rt_e = 9; rs_d = 7; rt_d = 9;
        exp_fwd("fwd_mix", 1, 2, 1, 2);
        finish_cycle();

        mem2reg_m = 1;
        exp_fwd("fwd_d_load_m", 1, 2, 0, 2);
        exp_ctrl("fwd_d_load_m", 0, 0);
        finish_cycle();

        // branch resolved in D
        idle();
        branch_d = 1; taken_d = 1; rs_d = 3; uses_rs_d = 1; rd_e = 3; reg_write_e = 1;
        exp_ctrl("br_e", 1, 0);
        finish_cycle();

        reg_write_e = 0; rd_e = 0;
        exp_ctrl("br_clear", 0, 1);
        finish_cycle();

        rd_m = 3; reg_write_m = 1; mem2reg_m = 1;
        exp_ctrl("br_load_m", 1, 0);
        finish_cycle();

        mem2reg_m = 0;
        exp_ctrl("br_alu_m", 0, 1);
        exp_fwd("br_alu_m", 0, 0, 1, 0);
        finish_cycle();

        // MDU: 4 busy cycles, read stalls while busy
        idle();
        mdu_start_d = 1;
        exp_ctrl("mdu_start", 0, 0);
        exp_busy("mdu_start", 0);
        finish_cycle();

        idle();
        mdu_read_d = 1;
        for (int i = 0; i < 4; i++) begin
            exp_ctrl($sformatf("mdu_rd_busy%0d", i), 1, 0);
            exp_busy($sformatf("mdu_rd_busy%0d", i), 1);
            finish_cycle();
        end
        mdu_start_d = 1;
        exp_ctrl("mdu_b2b", 0, 0);
        exp_busy("mdu_b2b", 0);
        finish_cycle();

        // start held while busy is stalled and must not reload the count
        mdu_read_d = 0;
        for (int i = 0; i < 4; i++) begin
            exp_ctrl($sformatf("mdu_start_busy%0d", i), 1, 0);
            exp_busy($sformatf("mdu_start_busy%0d", i), 1);
            finish_cycle();
        end
        mdu_start_d = 0;
        exp_ctrl("mdu_done", 0, 0);
        exp_busy("mdu_done", 0);
        finish_cycle();

        // reset mid-operation
        mdu_start_d = 1;
        exp_busy("mdu_rst_go", 0);
        finish_cycle();
        mdu_start_d = 0;
        for (int i = 0; i < 2; i++) begin
            exp_busy($sformatf("mdu_rst_busy%0d", i), 1);
            finish_cycle();
        end
        mdu_read_d = 1;
        #2;
        rst = 1'b1;
        #1;
        sc_exp = 0;
        exp_busy("rst_async", 0);
        exp_ctrl("rst_async", 0, 0);
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        mdu_start_d = 1;
        exp_ctrl("post_rst_start", 0, 0);
        exp_busy("post_rst_start", 0);
        finish_cycle();
        mdu_start_d = 0;
        for (int i = 0; i < 4; i++) begin
            exp_busy($sformatf("post_rst_busy%0d", i), 1);
            finish_cycle();
        end
        exp_busy("post_rst_idle", 0);
        finish_cycle();

        // stall counter saturates at 15, clear has priority
        idle();
        rd_e = 5; mem2reg_e = 1; reg_write_e = 1; rs_d = 5; uses_rs_d = 1;
        for (int i = 0; i < 20; i++) begin
            exp_ctrl($sformatf("sat%0d", i), 1, 0);
            finish_cycle();
        end
        stat_clr = 1;
        exp_ctrl("sat_clr", 1, 0);
        finish_cycle();
        idle();
        exp_ctrl("after_clr", 0, 0);
        finish_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter MDU_LAT, default 4, multi-cycle multiply/divide latency in cycles; legal range 1..255.
REQ-003 Parameter CNT_W, default 16, width of the stall statistics counter.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rs_d, rt_d  in  REG_AW each  source registers of the instruction in D.
REQ-007 uses_rs_d, uses_rt_d  in  1 each  D instruction actually reads rs / rt.
REQ-008 branch_d, taken_d, jump_d  in  1 each  D holds a branch (compared in D) / branch resolved taken / jump.
REQ-009 mdu_start_d, mdu_read_d  in  1 each  D issues a mult/div / reads hi-lo.
REQ-010 rs_e, rt_e  in  REG_AW each  source registers of the instruction in E.
REQ-011 rd_e, rd_m, rd_w  in  REG_AW each  destination registers in E / M / W.
REQ-012 reg_write_e, reg_write_m, reg_write_w, mem2reg_e, mem2reg_m  in  1 each  write-enable and load flags per stage.
REQ-013 stall_f, stall_d, flush_d, flush_e  out  1 each  pipeline control.
REQ-014 fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e  out  2 each  forwarding selects for D and E operands.
REQ-015 mdu_busy  out  1  multi-cycle unit occupied.
REQ-016 stall_cycles  out  CNT_W  saturating count of stalled cycles.
REQ-017 stat_clr  in  1  synchronous clear of stall_cycles.

Function
REQ-018 A register match is valid only when the producer's reg_write is 1 and its rd is nonzero; register 0 never matches.
REQ-019 fwd_x_e: 1 if rs_e/rt_e matches rd_m; else 2 if it matches rd_w; else 0 (M wins over W).
REQ-020 fwd_x_d: 1 if rs_d/rt_d matches rd_m and mem2reg_m=0; else 2 if it matches rd_w; else 0.
REQ-021 lw_stall: mem2reg_e=1 and rd_e matches a used D source (uses_rs_d/uses_rt_d gate).
REQ-022 br_stall: branch_d=1 and either rd_e matches a used D source, or mem2reg_m=1 and rd_m matches a used D source.
REQ-023 mdu_stall: (mdu_start_d or mdu_read_d) and mdu_busy.
REQ-024 stall = lw_stall | br_stall | mdu_stall; stall_f = stall_d = flush_e = stall, combinational, same cycle.
REQ-025 flush_d = (taken_d | jump_d) & ~stall; a stalled branch never flushes.
REQ-026 mdu counter cnt, width clog2(MDU_LAT+1): if mdu_start_d & ~stall load MDU_LAT; else if cnt!=0 decrement; else hold.
REQ-027 mdu_busy = (cnt != 0), derived from registered state only (no combinational loop through stall).
REQ-028 Back-to-back: a start accepted in the cycle cnt reaches 0 reloads; a start while busy is stalled until cnt=0.
REQ-029 stall_cycles: stat_clr=1 -> 0 (priority over increment); else +1 per cycle stall=1; holds at all-ones (saturates, never wraps).
REQ-030 All outputs except mdu_busy and stall_cycles are purely combinational functions of current inputs and cnt.

Reset
REQ-031 rst=1 forces cnt=0, mdu_busy=0, stall_cycles=0 immediately, independent of clk.
REQ-032 During rst, combinational outputs follow inputs with mdu_stall=0.
REQ-033 Reset asserted mid MDU operation abandons it; first cycle after deassert accepts a new start.

Verification
REQ-034 lw in E (rd_e=5, mem2reg_e=1, reg_write_e=1), D uses rs_d=5 -> stall_f=stall_d=flush_e=1, flush_d=0; next cycle with producer in M (rd_m=5, mem2reg_m=1) and non-branch D -> stall=0.
REQ-035 rd_m=rd_w=7 both writing, rs_e=7 -> fwd_a_e=1; same with reg_write_m=0 -> fwd_a_e=2; rd_m=rd_w=0 -> fwd_a_e=0.
REQ-036 branch_d=1, taken_d=1, rs_d=3 matches rd_e=3 with reg_write_e=1 -> stall=1, flush_d=0; producer gone -> flush_d=1, stall=0.
REQ-037 MDU_LAT=4: mdu_start_d pulse -> mdu_busy high exactly 4 cycles; mdu_read_d during those cycles stalls, in the 5th does not.
REQ-038 CNT_W=4, stall held 20 cycles -> stall_cycles stops at 15; stat_clr together with stall -> 0.
REQ-039 rst asserted 2 cycles into an MDU operation -> mdu_busy=0 asynchronously; new start after release gives 4 busy cycles.
